nn_layer: RTL
=============

# nn_layer

Parametrised binary-neuron layer: `NUM_NEURON` neurons run in parallel and share one serial binary input stream. Each neuron has its own binary weight. Every accepted input adds +1 to a neuron's signed accumulator if the input bit matches the neuron's weight (XNOR = 1), and adds −1 otherwise. After `FAN_IN` accepted inputs, the layer presents all accumulator values and their sign activations on a valid/ready output port. It is the multi-neuron, flow-controlled successor to the single ALU+aggregator neuron in the `nn` datapath.

## Interface
- `ACC_WIDTH`, 12: signed accumulator width per neuron. Must be ≥ 2.
- `NUM_NEURON`, 4: number of parallel neurons. Must be ≥ 1.
- `FAN_IN`, 16: number of inputs accumulated per result. Must be ≥ 1.
- Derived localparam `CNT_WIDTH = $clog2(FAN_IN)`, minimum 1.
- `clk`  in  1  the only clock; everything is sampled on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  an input beat is offered this cycle.
- `in_ready`  out  1  the layer can accept an input beat.
- `in_bit`  in  1  binary activation shared by all neurons.
- `in_weight`  in  `NUM_NEURON`  per-neuron binary weight; bit i belongs to neuron i.
- `out_valid`  out  1  a result is available.
- `out_ready`  in  1  the consumer accepts the result.
- `out_act`  out  `NUM_NEURON`  sign activation; bit i = 1 when acc[i] ≥ 0.
- `out_acc`  out  `NUM_NEURON*ACC_WIDTH`  accumulator values; neuron i occupies bits `[i*ACC_WIDTH +: ACC_WIDTH]`.

## Operation
- Two states:
  - ACC: `in_ready` = 1, `out_valid` = 0.
  - OUT: `in_ready` = 0, `out_valid` = 1.
- An input beat transfers when `in_valid & in_ready`. On a transfer:
  - Each neuron updates `acc[i] <= acc[i] + ((in_bit ~^ in_weight[i]) ? +1 : −1)`.
  - The beat counter `cnt` increments.
- On the transfer with `cnt == FAN_IN−1`, the layer enters OUT. `cnt` returns to 0 and the updated accumulators are kept.
- OUT holds `acc` and `out_act` stable. `in_valid` and its data are ignored.
- An output transfer happens when `out_valid & out_ready`. On that transfer all accumulators clear to 0 and the state returns to ACC.
- `out_acc` and `out_act` are driven directly from the accumulator registers. They are meaningful only while `out_valid` = 1.
- Tie rule: acc = 0 gives act = 1.
- Arithmetic is two's complement on `ACC_WIDTH` bits. Overflow handling is set by `NN_LAYER_SAT_EN`.
- Reset (`rst` = 1 at a clock edge):
  - Result: state ACC, `cnt` = 0, all acc = 0.
  - Outputs after reset: `in_ready` = 1, `out_valid` = 0, `out_act` = all 1s (acc = 0 ≥ 0), `out_acc` = 0.
  - Reset takes priority over any simultaneous input or output transfer.
  - A reset in the middle of an accumulation discards the partial result.
  - A reset in OUT discards the pending result.

## Timing
- `in_ready` is a function of state only. It must not depend on `in_valid`, so there is no combinational path from input to ready.
- `out_valid` depends on the state register only. It does not depend on `out_ready` combinationally.
- Latency: when the final beat transfers at edge t, `out_valid` is 1 in the cycle after edge t.
- Throughput: at most one result every `FAN_IN`+1 cycles, because OUT takes at least one cycle.
- Backpressure: OUT lasts as long as `out_ready` = 0, for any number of cycles. Outputs are held constant for the whole time.
- `FAN_IN` = 1: every accepted beat produces a result.

## Configuration
- `NN_LAYER_SAT_EN` defined: each accumulator saturates.
  - Upper limit: +(2^(`ACC_WIDTH`−1)−1).
  - Lower limit: −2^(`ACC_WIDTH`−1).
  - A step that would pass a limit leaves the accumulator at that limit.
- `NN_LAYER_SAT_EN` undefined: plain modulo-2^`ACC_WIDTH` wrap.
- The two modes give identical results whenever `FAN_IN` ≤ 2^(`ACC_WIDTH`−1)−1.

## Test plan
- **Basic result.** Defaults; 16 beats with `in_bit` = 1, `in_weight` = 4'b0101 → one cycle after the 16th beat, `out_valid` = 1, `out_acc` = {−16, +16, −16, +16} (neuron 3 down to neuron 0), `out_act` = 4'b0101.
- **Tie.** Defaults; 8 beats with `in_bit` = 1 and 8 beats with `in_bit` = 0, `in_weight` = 4'hF throughout → all acc = 0, `out_act` = 4'hF.
- **Backpressure.** Hold `out_ready` = 0 for 5 cycles while `in_valid` = 1 → `out_valid` stays 1, `in_ready` stays 0, outputs stay unchanged, no beats are counted. Raise `out_ready` → the next result is built from exactly 16 new beats.
- **Saturation.** `ACC_WIDTH` = 4, `FAN_IN` = 10, all beats matching:
  - With `NN_LAYER_SAT_EN` → acc = 7, act = 1.
  - Without it → acc = 4'b1010 (−6), act = 0.
- **Reset mid-operation.** Pulse `rst` for 1 cycle after 7 beats → the next 16 beats produce a fresh result with no carry-over. Pulse `rst` during OUT → `out_valid` drops on the next cycle.
- **Streaming.** `in_valid` and `out_ready` held at 1 → `out_valid` pulses for exactly 1 cycle every 17 cycles, and `in_ready` is 0 only during those cycles.

Source files
------------

// File: rtl/nn_layer.sv
// nn_layer: NUM_NEURON binary neurons share one serial input stream and accumulate XNOR +/-1 steps.
// Define NN_LAYER_SAT_EN to saturate accumulators; by default they wrap modulo 2^ACC_WIDTH.
module nn_layer #(
  parameter int unsigned ACC_WIDTH  = 12,
  parameter int unsigned NUM_NEURON = 4,
  parameter int unsigned FAN_IN     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_bit,
  input  logic [NUM_NEURON-1:0]           in_weight,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURON-1:0]           out_act,
  output logic [NUM_NEURON*ACC_WIDTH-1:0] out_acc
);

  localparam int unsigned CNT_WIDTH = (FAN_IN > 1) ? $clog2(FAN_IN) : 1;
  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(FAN_IN - 1);
  localparam logic [ACC_WIDTH-1:0] AccOne  = ACC_WIDTH'(1);

  localparam logic [0:0] StAcc = 1'b0;
  localparam logic [0:0] StOut = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 in_fire, out_fire;

  assign in_ready  = (state_q == StAcc);
  assign out_valid = (state_q == StOut);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (in_fire) begin
      if (cnt_q == CntLast) begin
        cnt_d   = '0;
        state_d = StOut;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end else if (out_fire) begin
      state_d = StAcc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAcc;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_NEURON; g++) begin : g_neuron
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 match;

    assign match = in_bit ~^ in_weight[g];

    always_comb begin
      acc_d = acc_q;
      if (out_fire) begin
        acc_d = '0;
      end else if (in_fire) begin
`ifdef NN_LAYER_SAT_EN
        // Hold at the two's-complement extremes instead of wrapping.
        if (match && (acc_q != {1'b0, {(ACC_WIDTH-1){1'b1}}})) begin
          acc_d = acc_q + AccOne;
        end else if (!match && (acc_q != {1'b1, {(ACC_WIDTH-1){1'b0}}})) begin
          acc_d = acc_q - AccOne;
        end
`else
        acc_d = match ? (acc_q + AccOne) : (acc_q - AccOne);
`endif
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        acc_q <= '0;
      end else begin
        acc_q <= acc_d;
      end
    end

    assign out_acc[g*ACC_WIDTH +: ACC_WIDTH] = acc_q;
    assign out_act[g] = ~acc_q[ACC_WIDTH-1];
  end

endmodule
